// File: rtl/present_core_arbiter.sv
// Round-robin front end that time-shares one iterative PRESENT-80 encrypt core
// among N_REQ requesters and returns tagged ciphertext (or a timeout error).
module present_core_arbiter #(
  parameter int unsigned N_REQ   = 4,
  parameter int unsigned KEY_W   = 80,
  parameter int unsigned BLK_W   = 64,
  parameter int unsigned TIMEOUT = 40
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [N_REQ-1:0]           req_valid,
  output logic [N_REQ-1:0]           req_ready,
  input  logic [N_REQ*KEY_W-1:0]     req_key,
  input  logic [N_REQ*BLK_W-1:0]     req_pt,
  output logic                       rsp_valid,
  input  logic                       rsp_ready,
  output logic [$clog2(N_REQ)-1:0]   rsp_id,
  output logic [BLK_W-1:0]           rsp_ct,
  output logic                       rsp_err,
  output logic                       busy,
  output logic                       core_rst_n,
  output logic [KEY_W-1:0]           core_key,
  output logic [BLK_W-1:0]           core_pt,
  input  logic                       core_done,
  input  logic [BLK_W-1:0]           core_ct
);

  localparam int unsigned ID_W  = $clog2(N_REQ);
  localparam int unsigned CNT_W = $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    RUN,
    CAPTURE,
    RESP
  } state_t;

  state_t             state_q, state_d;
  logic [ID_W-1:0]    last_q, last_d;
  logic [ID_W-1:0]    id_q, id_d;
  logic [KEY_W-1:0]   key_q, key_d;
  logic [BLK_W-1:0]   pt_q, pt_d;
  logic [BLK_W-1:0]   ct_q, ct_d;
  logic               err_q, err_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               rsp_valid_q, rsp_valid_d;
  logic               busy_q, busy_d;
  logic               core_rst_n_q, core_rst_n_d;

  logic               grant_vld;
  logic [ID_W-1:0]    grant_idx;
  logic [ID_W-1:0]    cand;

  // Scan offsets 1..N_REQ from the last winner; the first valid one wins.
  always_comb begin
    grant_vld = 1'b0;
    grant_idx = '0;
    cand      = '0;
    for (int unsigned k = 1; k <= N_REQ; k++) begin
      cand = ID_W'((32'(last_q) + k) % N_REQ);
      if (!grant_vld && req_valid[cand]) begin
        grant_vld = 1'b1;
        grant_idx = cand;
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    last_d    = last_q;
    id_d      = id_q;
    key_d     = key_q;
    pt_d      = pt_q;
    ct_d      = ct_q;
    err_d     = err_q;
    cnt_d     = cnt_q;
    req_ready = '0;

    unique case (state_q)
      IDLE: begin
        if (grant_vld && !rst) begin
          req_ready[grant_idx] = 1'b1;
          id_d    = grant_idx;
          key_d   = req_key[grant_idx*KEY_W +: KEY_W];
          pt_d    = req_pt[grant_idx*BLK_W +: BLK_W];
          state_d = LOAD;
        end
      end
      LOAD: begin
        cnt_d   = '0;
        state_d = RUN;
      end
      RUN: begin
        cnt_d = cnt_q + 1'b1;
        if (core_done) begin
          state_d = CAPTURE;
        end else if (cnt_d == CNT_W'(TIMEOUT)) begin
          ct_d    = '0;
          err_d   = 1'b1;
          state_d = RESP;
        end
      end
      CAPTURE: begin
        ct_d    = core_ct;
        err_d   = 1'b0;
        state_d = RESP;
      end
      RESP: begin
        if (rsp_ready) begin
          last_d  = id_q;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    // Outputs are registered, so they are derived from the next state.
    rsp_valid_d  = (state_d == RESP);
    busy_d       = (state_d != IDLE);
    core_rst_n_d = (state_d == RUN) || (state_d == CAPTURE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      last_q       <= ID_W'(N_REQ - 1);
      id_q         <= '0;
      key_q        <= '0;
      pt_q         <= '0;
      ct_q         <= '0;
      err_q        <= 1'b0;
      cnt_q        <= '0;
      rsp_valid_q  <= 1'b0;
      busy_q       <= 1'b0;
      core_rst_n_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      last_q       <= last_d;
      id_q         <= id_d;
      key_q        <= key_d;
      pt_q         <= pt_d;
      ct_q         <= ct_d;
      err_q        <= err_d;
      cnt_q        <= cnt_d;
      rsp_valid_q  <= rsp_valid_d;
      busy_q       <= busy_d;
      core_rst_n_q <= core_rst_n_d;
    end
  end

  assign rsp_valid  = rsp_valid_q;
  assign rsp_id     = id_q;
  assign rsp_ct     = ct_q;
  assign rsp_err    = err_q;
  assign busy       = busy_q;
  assign core_rst_n = core_rst_n_q;
  assign core_key   = key_q;
  assign core_pt    = pt_q;

endmodule

// File: tb/tb_present_core_arbiter.sv
// Bench for present_core_arbiter: PRESENT-80 core model plus a timeline-based
// reference of the arbiter, directed scenarios followed by random traffic.
module tb_present_core_arbiter;

  localparam int unsigned N_REQ   = 4;
  localparam int unsigned KEY_W   = 80;
  localparam int unsigned BLK_W   = 64;
  localparam int unsigned TIMEOUT = 40;

  logic                     clk = 1'b0;
  logic                     rst = 1'b1;
  logic [N_REQ-1:0]         req_valid = '0;
  logic [N_REQ-1:0]         req_ready;
  logic [N_REQ*KEY_W-1:0]   req_key = '0;
  logic [N_REQ*BLK_W-1:0]   req_pt = '0;
  logic                     rsp_valid;
  logic                     rsp_ready = 1'b0;
  logic [1:0]               rsp_id;
  logic [BLK_W-1:0]         rsp_ct;
  logic                     rsp_err;
  logic                     busy;
  logic                     core_rst_n;
  logic [KEY_W-1:0]         core_key;
  logic [BLK_W-1:0]         core_pt;
  logic                     core_done = 1'b0;
  logic [BLK_W-1:0]         core_ct;

  int  n_checks = 0;
  int  n_fail   = 0;
  int  cyc      = 0;
  bit  chk_en   = 1'b0;
  bit  hang     = 1'b0;

  present_core_arbiter #(
    .N_REQ  (N_REQ),
    .KEY_W  (KEY_W),
    .BLK_W  (BLK_W),
    .TIMEOUT(TIMEOUT)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_key   (req_key),
    .req_pt    (req_pt),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_id    (rsp_id),
    .rsp_ct    (rsp_ct),
    .rsp_err   (rsp_err),
    .busy      (busy),
    .core_rst_n(core_rst_n),
    .core_key  (core_key),
    .core_pt   (core_pt),
    .core_done (core_done),
    .core_ct   (core_ct)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // PRESENT-80 primitives
  function automatic logic [3:0] sbox(input logic [3:0] x);
    logic [63:0] t;
    t = 64'hC56B90AD3EF84712;
    return t[(15 - 32'(x)) * 4 +: 4];
  endfunction

  function automatic logic [63:0] p_round(input logic [63:0] s, input logic [63:0] rk);
    logic [63:0] x, y;
    x = s ^ rk;
    for (int i = 0; i < 16; i++) x[i*4 +: 4] = sbox(x[i*4 +: 4]);
    y = '0;
    for (int i = 0; i < 63; i++) y[(i * 16) % 63] = x[i];
    y[63] = x[63];
    return y;
  endfunction

  function automatic logic [79:0] k_update(input logic [79:0] k, input logic [4:0] rc);
    logic [79:0] r;
    r = {k[18:0], k[79:19]};
    r[79:76] = sbox(r[79:76]);
    r[19:15] = r[19:15] ^ rc;
    return r;
  endfunction

  function automatic logic [63:0] present_enc(input logic [79:0] key, input logic [63:0] pt);
    logic [63:0] s;
    logic [79:0] k;
    s = pt;
    k = key;
    for (int r = 1; r <= 31; r++) begin
      s = p_round(s, k[79:16]);
      k = k_update(k, 5'(r));
    end
    return s ^ k[79:16];
  endfunction

  // Iterative core: loads while core_rst_n=0, one round per cycle, done pulses after round 31.
  logic [63:0] cm_st = '0;
  logic [79:0] cm_k = '0;
  int          cm_rnd = 31;
  always @(posedge clk) begin
    if (core_rst_n === 1'b0) begin
      cm_st     <= core_pt;
      cm_k      <= core_key;
      cm_rnd    <= 0;
      core_done <= 1'b0;
    end else if (cm_rnd < 31) begin
      cm_st     <= p_round(cm_st, cm_k[79:16]);
      cm_k      <= k_update(cm_k, 5'(cm_rnd + 1));
      cm_rnd    <= cm_rnd + 1;
      core_done <= (cm_rnd == 30) && !hang;
    end else begin
      core_done <= 1'b0;
    end
  end
  assign core_ct = cm_st ^ cm_k[79:16];

  task automatic check(input string name, input logic [79:0] act, input logic [79:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic fail_timeout(input string name);
    n_checks++;
    n_fail++;
    $display("FAIL %s: got no event, expected one within 100 cycles (cycle %0d)", name, cyc);
  endtask

  // Reference: a job is an accept time plus a response start time; outputs follow from those.
  bit               m_busy = 1'b0, m_done = 1'b0, m_err = 1'b0;
  int               m_tacc, m_tresp, m_id, m_last = N_REQ - 1;
  logic [79:0]      m_key = '0;
  logic [63:0]      m_pt = '0, m_ct = '0;
  int               g, j;
  logic [N_REQ-1:0] e_ready;
  bit               e_rv, e_crst;

  always @(negedge clk) begin
    g = -1;
    if (!m_busy && !rst)
      for (int k = 1; k <= N_REQ; k++) begin
        j = (m_last + k) % N_REQ;
        if (g < 0 && req_valid[j]) g = j;
      end
    e_ready = (g >= 0) ? N_REQ'(1 << g) : '0;
    e_rv    = m_busy && (cyc >= m_tresp);
    e_crst  = m_busy && (cyc >= m_tacc + 2) && (cyc < m_tresp);

    if (chk_en) begin
      check("req_ready", req_ready, e_ready);
      check("busy", busy, m_busy);
      check("rsp_valid", rsp_valid, e_rv);
      check("core_rst_n", core_rst_n, e_crst);
      check("core_key", core_key, m_key);
      check("core_pt", core_pt, m_pt);
      if (e_rv) begin
        check("rsp_id", rsp_id, m_id);
        check("rsp_err", rsp_err, m_err);
        check("rsp_ct", rsp_ct, m_err ? 64'h0 : m_ct);
      end
    end

    if (rst) begin
      m_busy = 1'b0;
      m_last = N_REQ - 1;
      m_key  = '0;
      m_pt   = '0;
    end else if (!m_busy) begin
      if (g >= 0) begin
        m_busy  = 1'b1;
        m_done  = 1'b0;
        m_err   = 1'b1;
        m_tacc  = cyc;
        m_tresp = cyc + 2 + TIMEOUT;
        m_id    = g;
        m_key   = req_key[g*KEY_W +: KEY_W];
        m_pt    = req_pt[g*BLK_W +: BLK_W];
        m_ct    = present_enc(m_key, m_pt);
      end
    end else begin
      if (!m_done && core_done && cyc >= m_tacc + 2 && cyc < m_tresp) begin
        m_done  = 1'b1;
        m_err   = 1'b0;
        m_tresp = cyc + 2;
      end
      if (e_rv && rsp_ready) begin
        m_busy = 1'b0;
        m_last = m_id;
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst       = 1'b1;
    req_valid = '0;
    rsp_ready = 1'b0;
    hang      = 1'b0;
    step();
    step();
    rst = 1'b0;
  endtask

  task automatic set_req(input int i, input logic [79:0] key, input logic [63:0] pt);
    req_key[i*KEY_W +: KEY_W] = key;
    req_pt[i*BLK_W +: BLK_W]  = pt;
    req_valid[i]              = 1'b1;
  endtask

  task automatic wait_grant(output int idx, output int at);
    idx = -1;
    at  = cyc;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (req_ready != '0) begin
        for (int b = 0; b < N_REQ; b++) if (req_ready[b]) idx = b;
        at = cyc;
        return;
      end
    end
    fail_timeout("grant_wait");
  endtask

  task automatic wait_rsp(output int at);
    at = cyc;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (rsp_valid) begin
        at = cyc;
        return;
      end
    end
    fail_timeout("rsp_wait");
  endtask

  int               gi, ga, ra, hs;
  int               exp_order[4] = '{0, 2, 0, 2};
  logic [79:0]      rk;
  logic [63:0]      rp;
  logic [N_REQ-1:0] acc;

  initial begin
    check("enc_zero", present_enc('0, '0), 64'h5579C1387B228445);
    check("enc_ones", present_enc('1, '1), 64'h3333DCD3213210D2);

    // Reset values and single job latency
    do_reset();
    chk_en = 1'b1;
    @(negedge clk);
    check("rst_rsp_valid", rsp_valid, 0);
    check("rst_rsp_err", rsp_err, 0);
    check("rst_busy", busy, 0);
    check("rst_rsp_ct", rsp_ct, 0);
    check("rst_rsp_id", rsp_id, 0);
    check("rst_core_key", core_key, 0);
    check("rst_core_rst_n", core_rst_n, 0);
    step();
    rsp_ready = 1'b1;
    set_req(0, '0, '0);
    wait_grant(gi, ga);
    check("t1_grant", gi, 0);
    step();
    req_valid = '0;
    wait_rsp(ra);
    check("t1_latency", ra - ga, 35);
    check("t1_id", rsp_id, 0);
    check("t1_ct", rsp_ct, 64'h5579C1387B228445);
    check("t1_err", rsp_err, 0);

    // Alternating grants between two held requesters
    do_reset();
    rsp_ready = 1'b1;
    set_req(0, '1, '1);
    set_req(2, '1, '1);
    for (int n = 0; n < 4; n++) begin
      wait_grant(gi, ga);
      check("t2_order", gi, exp_order[n]);
      wait_rsp(ra);
      check("t2_ct", rsp_ct, 64'h3333DCD3213210D2);
    end
    step();
    req_valid = '0;

    // Back-pressure on the response channel
    do_reset();
    rk = 80'({$urandom, $urandom, $urandom});
    rp = {$urandom, $urandom};
    set_req(1, rk, rp);
    wait_grant(gi, ga);
    step();
    req_valid = '0;
    set_req(2, '0, 64'h0123456789ABCDEF);
    wait_rsp(ra);
    for (int n = 0; n < 10; n++) begin
      @(negedge clk);
      check("t3_id", rsp_id, 1);
      check("t3_ct", rsp_ct, present_enc(rk, rp));
      check("t3_busy", busy, 1);
      check("t3_no_ready", req_ready, 0);
    end
    step();
    rsp_ready = 1'b1;
    @(negedge clk);
    hs = cyc;
    step();
    rsp_ready = 1'b0;
    wait_grant(gi, ga);
    check("t3_next_grant", gi, 2);
    check("t3_grant_cycle", ga - hs, 1);
    step();
    req_valid = '0;
    rsp_ready = 1'b1;
    wait_rsp(ra);

    // Core timeout, then normal service
    do_reset();
    hang      = 1'b1;
    rsp_ready = 1'b1;
    set_req(0, 80'({$urandom, $urandom, $urandom}), {$urandom, $urandom});
    wait_grant(gi, ga);
    step();
    req_valid = '0;
    wait_rsp(ra);
    check("t4_to_latency", ra - ga, TIMEOUT + 2);
    check("t4_err", rsp_err, 1);
    check("t4_ct", rsp_ct, 0);
    step();
    hang = 1'b0;
    rk = 80'({$urandom, $urandom, $urandom});
    rp = {$urandom, $urandom};
    set_req(1, rk, rp);
    wait_grant(gi, ga);
    step();
    req_valid = '0;
    wait_rsp(ra);
    check("t4_after_id", rsp_id, 1);
    check("t4_after_err", rsp_err, 0);
    check("t4_after_ct", rsp_ct, present_enc(rk, rp));

    // Reset while the core is running
    do_reset();
    rsp_ready = 1'b1;
    set_req(1, '1, '0);
    wait_grant(gi, ga);
    step();
    req_valid = '0;
    repeat (10) step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    @(negedge clk);
    check("t5_busy", busy, 0);
    check("t5_core_rst_n", core_rst_n, 0);
    check("t5_rsp_valid", rsp_valid, 0);
    check("t5_core_key", core_key, 0);
    step();
    for (int i = 0; i < N_REQ; i++) set_req(i, 80'(i), 64'(i));
    wait_grant(gi, ga);
    check("t5_first", gi, 0);
    step();
    req_valid = '0;
    wait_rsp(ra);
    check("t5_latency", ra - ga, 35);
    check("t5_id", rsp_id, 0);

    // Wrap-around to the highest requester twice in a row
    do_reset();
    rsp_ready = 1'b1;
    for (int n = 0; n < 2; n++) begin
      set_req(3, 80'hABCDE, 64'h5A5A);
      wait_grant(gi, ga);
      check("t6_grant", gi, 3);
      step();
      req_valid = '0;
      wait_rsp(ra);
      check("t6_id", rsp_id, 3);
      step();
    end

    // Random traffic against the reference
    do_reset();
    acc = '0;
    repeat (3000) begin
      step();
      rst       = ($urandom_range(0, 599) == 0);
      rsp_ready = ($urandom_range(0, 2) != 0);
      if ($urandom_range(0, 149) == 0) hang = ~hang;
      for (int i = 0; i < N_REQ; i++) begin
        if (acc[i]) req_valid[i] = 1'b0;
        else if (!req_valid[i] && $urandom_range(0, 5) == 0)
          set_req(i, 80'({$urandom, $urandom, $urandom}), {$urandom, $urandom});
      end
      @(negedge clk);
      acc = req_ready;
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
